// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR tap delay line and its sequencer.
package fir_pkg;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    localparam int UNR         = 4;
    localparam int NTAPS       = 37;
    localparam int DWIDTH      = 15;
    localparam int BUFLEN      = NTAPS - 1 + UNR;
    // Shifts needed to fill the whole buffer with real samples.
    localparam int PRIME_BEATS = ceil_div(BUFLEN, UNR);
    // Zero beats needed to push the last real sample past the final tap.
    localparam int FLUSH_BEATS = ceil_div(NTAPS - 1, UNR);
    localparam int FILL_W      = $clog2(PRIME_BEATS + 1);
    localparam int FLUSH_W     = $clog2(FLUSH_BEATS + 1);

    typedef logic signed [DWIDTH-1:0] sample_t;
    // Index 0 is the oldest sample of the beat.
    typedef sample_t [UNR-1:0] beat_t;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        RUN,
        FLUSH,
        LAST,
        CLR
    } state_e;

endpackage

// File: rtl/fir_tap_seq_if.sv
// Handshake and tap-buffer control bundle between the sample framer, the
// sequencer and the tap buffer / MAC pair.
interface fir_tap_seq_if;
    import fir_pkg::*;

    logic               s_valid;
    logic               s_ready;
    logic               s_last;
    beat_t              s_data;
    logic               sh_en;
    beat_t              sh_din;
    logic               sh_clr;
    logic               m_valid;
    logic               m_ready;
    logic               m_last;
    logic [FILL_W-1:0]  fill_cnt;
    logic               busy;

    // Sequencer side: consumes input beats and MAC acknowledges.
    modport slave (
        input  s_valid, s_last, s_data, m_ready,
        output s_ready, sh_en, sh_din, sh_clr, m_valid, m_last, fill_cnt, busy
    );

    // Environment side: framer, tap buffer and MAC.
    modport master (
        output s_valid, s_last, s_data, m_ready,
        input  s_ready, sh_en, sh_din, sh_clr, m_valid, m_last, fill_cnt, busy
    );

endinterface

// File: rtl/fir_tap_seq.sv
// Tap delay line sequencer: gates the buffer shift, tracks buffer fill,
// flags complete tap windows for the MAC and drains the filter tail with
// zero beats at the end of every record before clearing the buffer.
module fir_tap_seq
    import fir_pkg::*;
(
    input  logic         CLK,
    input  logic         RST_N,
    fir_tap_seq_if.slave bus
);

    localparam logic [FILL_W-1:0]  PRIME_FILL = FILL_W'(PRIME_BEATS);
    localparam logic [FLUSH_W-1:0] FLUSH_FULL = FLUSH_W'(FLUSH_BEATS);
    localparam logic [FLUSH_W-1:0] FLUSH_END  = FLUSH_W'(FLUSH_BEATS - 1);

    state_e               state_q, state_d;
    logic [FILL_W-1:0]    fill_cnt_q, fill_cnt_d;
    logic [FLUSH_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic                 m_valid_q, m_valid_d;
    logic                 m_last_q, m_last_d;

    logic                 adv;
    logic                 accept;
    logic                 flush_shift;
    logic                 last_flush;
    logic                 window_done;
    logic                 s_ready_c;
    logic                 sh_en_c;
    logic                 sh_clr_c;
    beat_t                sh_din_c;

    // The buffer may only move when the MAC is not holding a window.
    assign adv         = !m_valid_q || bus.m_ready;
    assign accept      = bus.s_valid && s_ready_c;
    assign last_flush  = flush_shift && (flush_cnt_q == FLUSH_END);
    assign window_done = sh_en_c && (fill_cnt_d == PRIME_FILL);

    // Input acceptance and shift control for the current state.
    always_comb begin
        s_ready_c   = 1'b0;
        sh_en_c     = 1'b0;
        sh_din_c    = '0;
        sh_clr_c    = 1'b0;
        flush_shift = 1'b0;
        case (state_q)
            IDLE, PRIME, RUN: begin
                s_ready_c = adv;
                sh_en_c   = bus.s_valid && adv;
                sh_din_c  = bus.s_data;
            end
            FLUSH: begin
                // Zero beats advance whenever the MAC can take a window.
                sh_en_c     = adv;
                flush_shift = adv;
            end
            CLR: begin
                sh_clr_c = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Fill and flush counters; both restart from zero on the clear cycle.
    always_comb begin
        fill_cnt_d  = fill_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q == CLR) begin
            fill_cnt_d  = '0;
            flush_cnt_d = '0;
        end else begin
            if (sh_en_c && (fill_cnt_q != PRIME_FILL)) begin
                fill_cnt_d = fill_cnt_q + FILL_W'(1);
            end
            if (flush_shift && (flush_cnt_q != FLUSH_FULL)) begin
                flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
            end
        end
    end

    // Window flags: a new window replaces the consumed one in the same edge,
    // a consumed window with no replacement drops, otherwise hold.
    always_comb begin
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        if (window_done) begin
            m_valid_d = 1'b1;
            m_last_d  = last_flush;
        end else if (bus.m_ready) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end
    end

    // Next-state logic for the record sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = bus.s_last ? FLUSH : PRIME;
                end
            end
            PRIME: begin
                if (accept) begin
                    if (bus.s_last) begin
                        state_d = FLUSH;
                    end else if (fill_cnt_d == PRIME_FILL) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (accept && bus.s_last) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (last_flush) begin
                    state_d = LAST;
                end
            end
            LAST: begin
                if (m_valid_q && bus.m_ready) begin
                    state_d = CLR;
                end
            end
            CLR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter and window flag registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            fill_cnt_q  <= '0;
            flush_cnt_q <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
        end else begin
            fill_cnt_q  <= fill_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
        end
    end

    assign bus.s_ready  = s_ready_c;
    assign bus.sh_en    = sh_en_c;
    assign bus.sh_din   = sh_din_c;
    assign bus.sh_clr   = sh_clr_c;
    assign bus.m_valid  = m_valid_q;
    assign bus.m_last   = m_last_q;
    assign bus.fill_cnt = fill_cnt_q;
    assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_fir_tap_seq.sv
// Testbench for fir_tap_seq: drives records, rebuilds the tap buffer from
// the shift controls and compares every consumed window with the windows
// predicted directly from the record samples.
module tb_fir_tap_seq;
    import fir_pkg::*;

    typedef sample_t [BUFLEN-1:0] win_t;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    fir_tap_seq_if bus();

    fir_tap_seq dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int     n_checks = 0;
    int     n_pass   = 0;
    int     cyc      = 0;
    bit     rand_mr  = 1'b0;
    beat_t  cur_rec[$];

    win_t   tb_buf = '0;
    win_t   obs_win[$];
    bit     obs_last[$];
    int     obs_wcyc[$];
    beat_t  obs_beats[$];
    int     obs_clr = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Tap buffer as the parent would hold it, plus a log of consumed windows.
    always @(negedge CLK) begin
        if (!RST_N) begin
            tb_buf <= '0;
        end else begin
            if (bus.m_valid && bus.m_ready) begin
                obs_win.push_back(tb_buf);
                obs_last.push_back(bus.m_last);
                obs_wcyc.push_back(cyc);
            end
            if (bus.sh_en) begin
                obs_beats.push_back(bus.sh_din);
                tb_buf <= {bus.sh_din, tb_buf[BUFLEN-1:UNR]};
            end
            if (bus.sh_clr) begin
                tb_buf  <= '0;
                obs_clr <= obs_clr + 1;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        if (rand_mr) bus.m_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic clear_obs();
        obs_win.delete();
        obs_last.delete();
        obs_wcyc.delete();
        obs_beats.delete();
    endtask

    task automatic make_rec(input int n, input bit ramp);
        beat_t b;
        cur_rec.delete();
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < UNR; j++)
                b[j] = ramp ? sample_t'(UNR * i + j) : sample_t'($urandom);
            cur_rec.push_back(b);
        end
    endtask

    // Sample at flat position pos of the record followed by endless zeros.
    function automatic sample_t stream_sample(input int pos);
        int b;
        b = pos / UNR;
        if (pos < 0 || b >= cur_rec.size()) return '0;
        return cur_rec[b][pos % UNR];
    endfunction

    // Window after the k-th (0-based) beat of the zero-padded stream:
    // the BUFLEN most recent samples, oldest at index 0.
    function automatic win_t exp_window(input int k);
        win_t w;
        for (int j = 0; j < BUFLEN; j++)
            w[j] = stream_sample((k + 1) * UNR - BUFLEN + j);
        return w;
    endfunction

    task automatic drive_record(input int first, input bit gaps,
                                output int cycles, output bit to);
        bit acc;
        int guard;
        cycles = 0;
        to     = 1'b0;
        for (int i = first; i < cur_rec.size(); i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    bus.s_valid = 1'b0;
                    tick();
                    cycles++;
                end
            end
            bus.s_valid = 1'b1;
            bus.s_data  = cur_rec[i];
            bus.s_last  = (i == cur_rec.size() - 1);
            guard = 0;
            acc   = 1'b0;
            while (!acc && guard < 200) begin
                @(negedge CLK);
                acc = bus.s_ready;
                tick();
                cycles++;
                guard++;
            end
            if (!acc) begin
                to = 1'b1;
                break;
            end
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic wait_idle(output bit to);
        int g;
        g = 0;
        while (bus.busy && g < 400) begin
            tick();
            g++;
        end
        to = bus.busy;
    endtask

    task automatic test_reset();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        RST_N = 1'b0;
        repeat (3) tick();
        RST_N = 1'b1;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); else n_pass++;
        n_checks++; if (bus.m_last !== 1'b0) $display("FAIL reset_m_last: got %b want 0", bus.m_last); else n_pass++;
        n_checks++; if (bus.fill_cnt !== '0) $display("FAIL reset_fill_cnt: got %0d want 0", bus.fill_cnt); else n_pass++;
        n_checks++; if (bus.sh_clr !== 1'b0) $display("FAIL reset_sh_clr: got %b want 0", bus.sh_clr); else n_pass++;
        n_checks++; if (bus.s_ready !== 1'b1) $display("FAIL reset_s_ready: got %b want 1", bus.s_ready); else n_pass++;
        n_checks++; if (bus.sh_en !== 1'b0) $display("FAIL reset_sh_en: got %b want 0", bus.sh_en); else n_pass++;
    endtask

    task automatic test_prime();
        int cy;
        bit to;
        int n;
        rand_mr = 1'b0;
        bus.m_ready = 1'b1;
        make_rec(PRIME_BEATS + 1, 1'b1);
        n = cur_rec.size();
        clear_obs();
        for (int k = 0; k < PRIME_BEATS; k++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = cur_rec[k];
            bus.s_last  = 1'b0;
            @(negedge CLK);
            n_checks++;
            if (bus.m_valid !== 1'b0 || bus.sh_en !== 1'b1)
                $display("FAIL prime_early beat %0d: m_valid=%b sh_en=%b want 0/1", k, bus.m_valid, bus.sh_en);
            else n_pass++;
            tick();
        end
        bus.s_valid = 1'b0;
        n_checks++; if (bus.m_valid !== 1'b1) $display("FAIL prime_m_valid: got %b want 1", bus.m_valid); else n_pass++;
        n_checks++; if (bus.fill_cnt !== FILL_W'(PRIME_BEATS)) $display("FAIL prime_fill_cnt: got %0d want %0d", bus.fill_cnt, PRIME_BEATS); else n_pass++;
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL prime_busy: got %b want 1", bus.busy); else n_pass++;
        n_checks++; if (tb_buf !== exp_window(PRIME_BEATS - 1)) $display("FAIL prime_window: got %h want %h", tb_buf, exp_window(PRIME_BEATS - 1)); else n_pass++;
        drive_record(PRIME_BEATS, 1'b0, cy, to);
        if (!to) wait_idle(to);
        n_checks++; if (to) $display("FAIL prime_timeout: got timeout want completion"); else n_pass++;
        n_checks++; if (obs_win.size() !== n) $display("FAIL prime_count: got %0d windows want %0d", obs_win.size(), n); else n_pass++;
        for (int w = 0; w < obs_win.size() && w < n; w++) begin
            n_checks++;
            if (obs_win[w] !== exp_window(w + PRIME_BEATS - 1) || obs_last[w] !== (w == n - 1))
                $display("FAIL prime_win %0d: got last=%b %h want last=%b %h", w, obs_last[w], obs_win[w], (w == n - 1), exp_window(w + PRIME_BEATS - 1));
            else n_pass++;
        end
    endtask

    task automatic test_steady();
        int cy, n, bad, clr0;
        bit to;
        beat_t eb;
        rand_mr = 1'b0;
        bus.m_ready = 1'b1;
        make_rec(50, 1'b0);
        n = cur_rec.size();
        clear_obs();
        clr0 = obs_clr;
        drive_record(0, 1'b0, cy, to);
        n_checks++; if (to || cy !== n) $display("FAIL steady_cycles: got %0d cycles want %0d", cy, n); else n_pass++;
        wait_idle(to);
        n_checks++; if (to) $display("FAIL steady_timeout: got timeout want completion"); else n_pass++;
        n_checks++; if (obs_win.size() !== n) $display("FAIL steady_count: got %0d windows want %0d", obs_win.size(), n); else n_pass++;
        for (int w = 0; w < obs_win.size() && w < n; w++) begin
            n_checks++;
            if (obs_win[w] !== exp_window(w + PRIME_BEATS - 1) || obs_last[w] !== (w == n - 1))
                $display("FAIL steady_win %0d: got last=%b %h want last=%b %h", w, obs_last[w], obs_win[w], (w == n - 1), exp_window(w + PRIME_BEATS - 1));
            else n_pass++;
        end
        n_checks++;
        if (obs_wcyc.size() == n && obs_wcyc[n-1] - obs_wcyc[0] !== n - 1)
            $display("FAIL steady_gapless: got span %0d want %0d", obs_wcyc[n-1] - obs_wcyc[0], n - 1);
        else if (obs_wcyc.size() != n) $display("FAIL steady_gapless: got %0d windows want %0d", obs_wcyc.size(), n);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < obs_beats.size(); i++) begin
            eb = (i < n) ? cur_rec[i] : '0;
            if (obs_beats[i] !== eb) bad++;
        end
        n_checks++;
        if (obs_beats.size() !== n + FLUSH_BEATS || bad != 0)
            $display("FAIL steady_sh_din: got %0d shifts %0d wrong want %0d shifts 0 wrong", obs_beats.size(), bad, n + FLUSH_BEATS);
        else n_pass++;
        n_checks++; if (obs_clr - clr0 !== 1) $display("FAIL steady_clr: got %0d clears want 1", obs_clr - clr0); else n_pass++;
    endtask

    task automatic test_backpressure();
        int n, g;
        bit to, acc;
        rand_mr = 1'b0;
        bus.m_ready = 1'b1;
        make_rec(20, 1'b0);
        n = cur_rec.size();
        clear_obs();
        for (int k = 0; k < n; k++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = cur_rec[k];
            bus.s_last  = (k == n - 1);
            if (k == 14) begin
                bus.m_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge CLK);
                    n_checks++;
                    if (bus.s_ready !== 1'b0 || bus.sh_en !== 1'b0 || bus.m_valid !== 1'b1)
                        $display("FAIL bp_stall cycle %0d: s_ready=%b sh_en=%b m_valid=%b want 0/0/1", c, bus.s_ready, bus.sh_en, bus.m_valid);
                    else n_pass++;
                    tick();
                end
                bus.m_ready = 1'b1;
            end
            @(negedge CLK);
            acc = bus.s_ready;
            tick();
            n_checks++; if (acc !== 1'b1) $display("FAIL bp_accept beat %0d: got s_ready=%b want 1", k, acc); else n_pass++;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        wait_idle(to);
        g = obs_win.size();
        n_checks++; if (to) $display("FAIL bp_timeout: got timeout want completion"); else n_pass++;
        n_checks++; if (g !== n) $display("FAIL bp_count: got %0d windows want %0d", g, n); else n_pass++;
        for (int w = 0; w < g && w < n; w++) begin
            n_checks++;
            if (obs_win[w] !== exp_window(w + PRIME_BEATS - 1) || obs_last[w] !== (w == n - 1))
                $display("FAIL bp_win %0d: got last=%b %h want last=%b %h", w, obs_last[w], obs_win[w], (w == n - 1), exp_window(w + PRIME_BEATS - 1));
            else n_pass++;
        end
    endtask

    task automatic test_short_record();
        int cy, bad, clr0;
        bit to;
        rand_mr = 1'b0;
        bus.m_ready = 1'b1;
        make_rec(1, 1'b0);
        clear_obs();
        clr0 = obs_clr;
        drive_record(0, 1'b0, cy, to);
        if (!to) wait_idle(to);
        n_checks++; if (to) $display("FAIL short_timeout: got timeout want completion"); else n_pass++;
        bad = 0;
        for (int i = 1; i < obs_beats.size(); i++) if (obs_beats[i] !== '0) bad++;
        n_checks++;
        if (obs_beats.size() !== 1 + FLUSH_BEATS || bad != 0 || obs_beats[0] !== cur_rec[0])
            $display("FAIL short_flush: got %0d shifts %0d nonzero pads want %0d shifts 0 nonzero", obs_beats.size(), bad, 1 + FLUSH_BEATS);
        else n_pass++;
        n_checks++; if (obs_win.size() !== 1) $display("FAIL short_count: got %0d windows want 1", obs_win.size()); else n_pass++;
        if (obs_win.size() > 0) begin
            n_checks++;
            if (obs_win[0] !== exp_window(PRIME_BEATS - 1) || obs_last[0] !== 1'b1)
                $display("FAIL short_win: got last=%b %h want last=1 %h", obs_last[0], obs_win[0], exp_window(PRIME_BEATS - 1));
            else n_pass++;
        end
        n_checks++; if (obs_clr - clr0 !== 1) $display("FAIL short_clr: got %0d clear cycles want 1", obs_clr - clr0); else n_pass++;
        n_checks++; if (bus.fill_cnt !== '0 || bus.busy !== 1'b0) $display("FAIL short_idle: got fill_cnt=%0d busy=%b want 0/0", bus.fill_cnt, bus.busy); else n_pass++;
    endtask

    task automatic test_record_end();
        int cy, n, lasts;
        bit to;
        rand_mr = 1'b1;
        make_rec(12, 1'b0);
        n = cur_rec.size();
        clear_obs();
        drive_record(0, 1'b1, cy, to);
        if (!to) wait_idle(to);
        n_checks++; if (to) $display("FAIL end_timeout: got timeout want completion"); else n_pass++;
        n_checks++; if (obs_win.size() !== n) $display("FAIL end_count: got %0d windows want %0d", obs_win.size(), n); else n_pass++;
        lasts = 0;
        foreach (obs_last[i]) if (obs_last[i]) lasts++;
        n_checks++;
        if (lasts !== 1 || obs_last.size() != n || obs_last[n-1] !== 1'b1)
            $display("FAIL end_m_last: got %0d last flags want exactly 1 on window %0d", lasts, n);
        else n_pass++;
        n_checks++; if (bus.busy !== 1'b0 || bus.fill_cnt !== '0) $display("FAIL end_idle: got busy=%b fill_cnt=%0d want 0/0", bus.busy, bus.fill_cnt); else n_pass++;
        rand_mr = 1'b0;
        bus.m_ready = 1'b1;
        make_rec(PRIME_BEATS, 1'b1);
        clear_obs();
        drive_record(0, 1'b0, cy, to);
        if (!to) wait_idle(to);
        n_checks++;
        if (to || obs_win.size() != PRIME_BEATS || obs_win[0] !== exp_window(PRIME_BEATS - 1))
            $display("FAIL end_reprime: got %0d windows timeout=%b want %0d windows, first from fresh record", obs_win.size(), to, PRIME_BEATS);
        else n_pass++;
    endtask

    task automatic test_reset_flush();
        int cy, nfl, g;
        bit to;
        rand_mr = 1'b0;
        bus.m_ready = 1'b1;
        make_rec(15, 1'b0);
        clear_obs();
        drive_record(0, 1'b0, cy, to);
        nfl = 0;
        g   = 0;
        while (nfl < 4 && g < 50) begin
            @(negedge CLK);
            if (bus.sh_en) nfl++;
            tick();
            g++;
        end
        n_checks++; if (to || nfl !== 4) $display("FAIL rst_reach_flush: got %0d flush shifts want 4", nfl); else n_pass++;
        RST_N = 1'b0;
        bus.m_ready = 1'b0;
        tick();
        RST_N = 1'b1;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.m_valid !== 1'b0) $display("FAIL rst_m_valid: got %b want 0", bus.m_valid); else n_pass++;
        n_checks++; if (bus.m_last !== 1'b0) $display("FAIL rst_m_last: got %b want 0", bus.m_last); else n_pass++;
        n_checks++; if (bus.fill_cnt !== '0) $display("FAIL rst_fill_cnt: got %0d want 0", bus.fill_cnt); else n_pass++;
        n_checks++; if (bus.sh_clr !== 1'b0) $display("FAIL rst_sh_clr: got %b want 0", bus.sh_clr); else n_pass++;
        n_checks++; if (bus.s_ready !== 1'b1) $display("FAIL rst_s_ready: got %b want 1", bus.s_ready); else n_pass++;
        bus.m_ready = 1'b1;
        make_rec(3, 1'b0);
        clear_obs();
        drive_record(0, 1'b0, cy, to);
        if (!to) wait_idle(to);
        n_checks++;
        if (to || obs_win.size() != 3 || obs_win[0] !== exp_window(PRIME_BEATS - 1))
            $display("FAIL rst_recover: got %0d windows timeout=%b want 3", obs_win.size(), to);
        else n_pass++;
    endtask

    task automatic test_random_records();
        int cy, n, bad, clr0;
        bit to;
        beat_t eb;
        rand_mr = 1'b1;
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 16);
            make_rec(n, 1'b0);
            clear_obs();
            clr0 = obs_clr;
            drive_record(0, 1'b1, cy, to);
            if (!to) wait_idle(to);
            n_checks++; if (to) $display("FAIL rand_timeout rec %0d: got timeout want completion", r); else n_pass++;
            n_checks++; if (obs_win.size() !== n) $display("FAIL rand_count rec %0d: got %0d windows want %0d", r, obs_win.size(), n); else n_pass++;
            bad = 0;
            for (int w = 0; w < obs_win.size() && w < n; w++)
                if (obs_win[w] !== exp_window(w + PRIME_BEATS - 1) || obs_last[w] !== (w == n - 1)) bad++;
            n_checks++; if (bad != 0) $display("FAIL rand_windows rec %0d: got %0d wrong windows want 0", r, bad); else n_pass++;
            bad = 0;
            for (int i = 0; i < obs_beats.size(); i++) begin
                eb = (i < n) ? cur_rec[i] : '0;
                if (obs_beats[i] !== eb) bad++;
            end
            n_checks++;
            if (obs_beats.size() !== n + FLUSH_BEATS || bad != 0)
                $display("FAIL rand_sh_din rec %0d: got %0d shifts %0d wrong want %0d shifts", r, obs_beats.size(), bad, n + FLUSH_BEATS);
            else n_pass++;
            n_checks++; if (obs_clr - clr0 !== 1) $display("FAIL rand_clr rec %0d: got %0d clears want 1", r, obs_clr - clr0); else n_pass++;
        end
        rand_mr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_prime();
        test_steady();
        test_backpressure();
        test_short_record();
        test_record_end();
        test_reset_flush();
        test_random_records();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
